// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl -- programmable interrupt controller feeding one CP0 itr line.
//
// Collects up to NSRC peripheral requests, synchronizes them, applies per-source
// edge/level detection and enable masking, and selects the highest-priority
// (lowest-index) request that outranks everything currently in service.
// Software claims and retires interrupts through a small register window.
//
// Ports:
//   clk    in   1      system clock
//   reset  in   1      asynchronous, active-high reset
//   src    in   NSRC   raw peripheral requests (asynchronous to clk)
//   addr   in   3      word address (byte offset [4:2])
//   we     in   1      bus write strobe
//   re     in   1      bus read strobe (qualifies the CLAIM side effect)
//   wd     in   32     write data
//   rd     out  32     read data, combinational from addr
//   itr    out  6      CP0 interrupt input; only bit IRQ_LINE is ever driven
//
// Register window (byte offset):
//   0x00 ENABLE rw, 0x04 MODE rw (1=edge), 0x08 PENDING r / W1C (edge bits),
//   0x0C CLAIM r {valid,27'b0,index}, 0x10 EOI w, 0x14 INSERVICE r.
// -----------------------------------------------------------------------------
module intr_ctrl #(
    parameter int NSRC     = 8,
    parameter int IRQ_LINE = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [2:0]      addr,
    input  logic            we,
    input  logic            re,
    input  logic [31:0]     wd,
    output logic [31:0]     rd,
    output logic [5:0]      itr
);

    localparam logic [2:0] ADDR_ENABLE    = 3'd0;
    localparam logic [2:0] ADDR_MODE      = 3'd1;
    localparam logic [2:0] ADDR_PENDING   = 3'd2;
    localparam logic [2:0] ADDR_CLAIM     = 3'd3;
    localparam logic [2:0] ADDR_EOI       = 3'd4;
    localparam logic [2:0] ADDR_INSERVICE = 3'd5;

    // Synchronizer and edge history
    logic [NSRC-1:0] s1_q;
    logic [NSRC-1:0] s2_q;
    logic [NSRC-1:0] p_q;

    // Architectural state
    logic [NSRC-1:0] enable_q,    enable_d;
    logic [NSRC-1:0] mode_q,      mode_d;
    logic [NSRC-1:0] edge_pend_q, edge_pend_d;
    logic [NSRC-1:0] insvc_q,     insvc_d;
    logic            itr_q,       itr_d;

    // Combinational helpers
    logic [NSRC-1:0] pending_s;
    logic [NSRC-1:0] cand_onehot_s;
    logic [3:0]      cand_idx_s;
    logic            cand_valid_s;
    logic            blocked_s;
    logic            hit_s;
    logic            claim_s;
    logic [NSRC-1:0] claim_clr_s;
    logic [NSRC-1:0] eoi_clr_s;
    logic [NSRC-1:0] w1c_s;
    logic [NSRC-1:0] edge_set_s;

    // Effective pending vector and fixed-priority candidate selection
    always_comb begin
        pending_s     = (mode_q & edge_pend_q) | (~mode_q & s2_q);
        cand_onehot_s = {NSRC{1'b0}};
        cand_idx_s    = 4'd0;
        cand_valid_s  = 1'b0;
        blocked_s     = 1'b0;
        hit_s         = 1'b0;
        // A source at or below the lowest in-service index can never preempt,
        // so blocked_s latches on as soon as the scan reaches an in-service bit.
        for (int i = 0; i < NSRC; i++) begin
            blocked_s        = blocked_s | insvc_q[i];
            hit_s            = ~blocked_s & ~cand_valid_s & pending_s[i] & enable_q[i];
            cand_onehot_s[i] = hit_s;
            cand_idx_s       = hit_s ? 4'(i) : cand_idx_s;
            cand_valid_s     = cand_valid_s | hit_s;
        end
    end

    // Bus side effects and next-state computation
    always_comb begin
        claim_s     = re & (addr == ADDR_CLAIM) & cand_valid_s;
        claim_clr_s = cand_onehot_s & {NSRC{claim_s}};
        // Decode by comparison so that indices >= NSRC never alias a real bit.
        for (int i = 0; i < NSRC; i++) begin
            eoi_clr_s[i] = we & (addr == ADDR_EOI) & (wd[3:0] == 4'(i));
        end
        if (we && (addr == ADDR_PENDING)) begin
            w1c_s = wd[NSRC-1:0] & mode_q;
        end else begin
            w1c_s = {NSRC{1'b0}};
        end
        edge_set_s = s2_q & ~p_q & mode_q;

        // Set wins over W1C/claim; latch is held clear while a bit is in level
        // mode so a later switch back to edge starts without stale state.
        edge_pend_d = ((edge_pend_q & ~w1c_s & ~claim_clr_s) | edge_set_s) & mode_q;
        // Claim set wins over an EOI of the same index.
        insvc_d     = (insvc_q & ~eoi_clr_s) | claim_clr_s;

        if (we && (addr == ADDR_ENABLE)) begin
            enable_d = wd[NSRC-1:0];
        end else begin
            enable_d = enable_q;
        end
        if (we && (addr == ADDR_MODE)) begin
            mode_d = wd[NSRC-1:0];
        end else begin
            mode_d = mode_q;
        end
        itr_d = cand_valid_s;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q        <= {NSRC{1'b0}};
            s2_q        <= {NSRC{1'b0}};
            p_q         <= {NSRC{1'b0}};
            enable_q    <= {NSRC{1'b0}};
            mode_q      <= {NSRC{1'b0}};
            edge_pend_q <= {NSRC{1'b0}};
            insvc_q     <= {NSRC{1'b0}};
            itr_q       <= 1'b0;
        end else begin
            s1_q        <= src;
            s2_q        <= s1_q;
            p_q         <= s2_q;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            edge_pend_q <= edge_pend_d;
            insvc_q     <= insvc_d;
            itr_q       <= itr_d;
        end
    end

    // Read data mux
    always_comb begin
        case (addr)
            ADDR_ENABLE:    rd = {{(32-NSRC){1'b0}}, enable_q};
            ADDR_MODE:      rd = {{(32-NSRC){1'b0}}, mode_q};
            ADDR_PENDING:   rd = {{(32-NSRC){1'b0}}, pending_s};
            ADDR_CLAIM:     rd = {cand_valid_s, 27'd0, cand_idx_s};
            ADDR_INSERVICE: rd = {{(32-NSRC){1'b0}}, insvc_q};
            default:        rd = 32'd0;
        endcase
    end

    // Drive only the configured CP0 interrupt bit
    always_comb begin
        itr           = 6'd0;
        itr[IRQ_LINE] = itr_q;
    end

endmodule

// File: tb/tb_intr_ctrl.sv
`timescale 1ns/1ps
module tb_intr_ctrl;

    localparam int NSRC     = 8;
    localparam int IRQ_LINE = 2;
    localparam logic [31:0] ITR_ON = 32'h0000_0004;

    logic            clk;
    logic            reset;
    logic [NSRC-1:0] src;
    logic [2:0]      addr;
    logic            we;
    logic            re;
    logic [31:0]     wd;
    logic [31:0]     rd;
    logic [5:0]      itr;

    intr_ctrl #(.NSRC(NSRC), .IRQ_LINE(IRQ_LINE)) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .addr  (addr),
        .we    (we),
        .re    (re),
        .wd    (wd),
        .rd    (rd),
        .itr   (itr)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] v);
        addr = a;
        re   = 1'b0;
        #1;
        v = rd;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        expect_val(tag, exp);
        rd_reg(a, v);
        compare(v);
    endtask

    task automatic check_itr(input string tag, input logic [31:0] exp);
        expect_val(tag, exp);
        compare({26'd0, itr});
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        wd   = 32'd0;
    endtask

    // CLAIM read: rd is sampled before the claiming edge, side effect at the edge
    task automatic claim(input string tag, input logic [31:0] exp);
        logic [31:0] v;
        expect_val(tag, exp);
        addr = 3'd3;
        re   = 1'b1;
        #1;
        v = rd;
        @(negedge clk);
        re = 1'b0;
        compare(v);
    endtask

    task automatic pulse(input logic [NSRC-1:0] m);
        src = m;
        @(negedge clk);
        src = {NSRC{1'b0}};
    endtask

    initial begin
        reset = 1'b1;
        src   = {NSRC{1'b0}};
        addr  = 3'd0;
        we    = 1'b0;
        re    = 1'b0;
        wd    = 32'd0;
        tick(2);

        // Reset state
        check_reg("rst_enable",  3'd0, 32'h0);
        check_reg("rst_mode",    3'd1, 32'h0);
        check_reg("rst_pending", 3'd2, 32'h0);
        check_reg("rst_claim",   3'd3, 32'h0);
        check_reg("rst_insvc",   3'd5, 32'h0);
        check_itr("rst_itr", 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);

        // Edge source 3, single-cycle pulse
        bus_write(3'd0, 32'h08);
        bus_write(3'd1, 32'h08);
        pulse(8'h08);
        tick(2);
        check_itr("e3_itr_not_yet", 32'h0);
        check_reg("e3_pending", 3'd2, 32'h08);
        tick(1);
        check_itr("e3_itr_high", ITR_ON);
        claim("e3_claim", 32'h8000_0003);
        check_reg("e3_pend_clr", 3'd2, 32'h0);
        check_reg("e3_insvc", 3'd5, 32'h08);
        tick(1);
        check_itr("e3_itr_low", 32'h0);
        bus_write(3'd4, 32'd3);
        check_reg("e3_eoi", 3'd5, 32'h0);

        // Sources 5 and 1 together
        bus_write(3'd0, 32'h22);
        bus_write(3'd1, 32'h22);
        check_reg("p_enable_rb", 3'd0, 32'h22);
        check_reg("p_unused_off", 3'd6, 32'h0);
        pulse(8'h22);
        tick(3);
        check_itr("p_itr", ITR_ON);
        claim("p_claim1", 32'h8000_0001);
        claim("p_claim_none", 32'h0);
        check_reg("p_pend5_kept", 3'd2, 32'h20);
        check_itr("p_itr_low", 32'h0);
        bus_write(3'd4, 32'd1);
        claim("p_claim5", 32'h8000_0005);
        bus_write(3'd4, 32'd5);
        check_reg("p_insvc_clr", 3'd5, 32'h0);

        // Nesting: 4 in service, 2 preempts
        bus_write(3'd0, 32'h14);
        bus_write(3'd1, 32'h14);
        pulse(8'h10);
        tick(3);
        claim("n_claim4", 32'h8000_0004);
        tick(1);
        check_itr("n_itr_low", 32'h0);
        pulse(8'h04);
        tick(3);
        check_itr("n_itr_nest", ITR_ON);
        claim("n_claim2", 32'h8000_0002);
        check_reg("n_insvc", 3'd5, 32'h14);
        bus_write(3'd4, 32'd12);
        check_reg("n_eoi_oob", 3'd5, 32'h14);
        bus_write(3'd4, 32'd2);
        bus_write(3'd4, 32'd4);
        check_reg("n_insvc_clr", 3'd5, 32'h0);

        // Level source 0 held high
        bus_write(3'd0, 32'h01);
        bus_write(3'd1, 32'h00);
        src = 8'h01;
        tick(2);
        check_reg("l_pending", 3'd2, 32'h01);
        tick(1);
        check_itr("l_itr", ITR_ON);
        claim("l_claim0", 32'h8000_0000);
        check_reg("l_pend_kept", 3'd2, 32'h01);
        tick(2);
        check_itr("l_no_refire", 32'h0);
        claim("l_claim_none", 32'h0);
        bus_write(3'd4, 32'd0);
        tick(1);
        check_itr("l_itr_reassert", ITR_ON);
        src = 8'h00;
        tick(2);
        check_itr("l_itr_still", ITR_ON);
        tick(1);
        check_itr("l_itr_drop", 32'h0);

        // W1C colliding with a new edge on source 6, masked by ENABLE
        bus_write(3'd0, 32'h00);
        bus_write(3'd1, 32'h40);
        pulse(8'h40);
        tick(1);
        bus_write(3'd2, 32'h40);
        check_reg("w_set_wins", 3'd2, 32'h40);
        tick(2);
        check_itr("w_masked", 32'h0);
        bus_write(3'd0, 32'h40);
        tick(1);
        check_itr("w_enabled", ITR_ON);
        bus_write(3'd2, 32'h40);
        check_reg("w_w1c", 3'd2, 32'h0);
        tick(1);
        check_itr("w_itr_low", 32'h0);

        // Asynchronous reset with pending and in-service state
        bus_write(3'd0, 32'h80);
        bus_write(3'd1, 32'h80);
        pulse(8'h80);
        tick(3);
        claim("r_claim7", 32'h8000_0007);
        pulse(8'h80);
        tick(3);
        check_reg("r_pending", 3'd2, 32'h80);
        check_reg("r_insvc", 3'd5, 32'h80);
        @(negedge clk);
        #2;
        reset = 1'b1;
        check_reg("r_enable0",  3'd0, 32'h0);
        check_reg("r_mode0",    3'd1, 32'h0);
        check_reg("r_pending0", 3'd2, 32'h0);
        check_reg("r_insvc0",   3'd5, 32'h0);
        check_itr("r_itr0", 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);

        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Programmable interrupt controller that feeds the 6-bit hardware-interrupt input of the CPU's coprocessor-0 block. It collects up to 16 peripheral request lines and handles edge or level detection, enable masking and fixed-priority selection. Software claims and retires interrupts through a small memory-mapped register window on the system bridge. Nesting is supported: a request is presented to the CPU only when it outranks everything currently in service.

## Interface
- NSRC, 8, number of interrupt sources (1..16); source index 0 has the highest priority.
- IRQ_LINE, 2, bit of itr driven by this block (0..5).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- src  in  NSRC  raw peripheral requests; asynchronous to clk.
- addr  in  3  word address, byte offset [4:2].
- we  in  1  bus write strobe.
- re  in  1  bus read strobe (qualifies read side effects).
- wd  in  32  write data.
- rd  out  32  read data, combinational from addr.
- itr  out  6  to CP0 interrupt input; only bit IRQ_LINE is ever nonzero.

## Operation
- Synchronizer: two flops per source (s1, s2), plus a history flop p = previous s2.
- Registers, by byte offset:
  - 0x00 ENABLE rw [NSRC-1:0].
  - 0x04 MODE rw: 1 = edge, 0 = level.
  - 0x08 PENDING:
    - read returns the pending vector;
    - write-1-to-clear affects edge-mode bits only.
  - 0x0C CLAIM r: {valid[31], 27'b0, index[3:0]}.
  - 0x10 EOI w: wd[3:0] = index to retire.
  - 0x14 INSERVICE r.
  - Other offsets read 0 and writes are ignored. Unused upper bits read 0.
- Pending:
  - Edge mode: the bit sets when s2 & ~p, and clears on W1C or claim.
  - Level mode: pending = s2 (not latched). W1C has no effect.
- Candidate: the lowest index i with pending[i] & enable[i] and i < lowest set INSERVICE index (any i qualifies if INSERVICE = 0).
- CLAIM read:
  - rd shows the current candidate, or 0 if there is none.
  - On a clock edge with re=1, addr=3 and a valid candidate: INSERVICE[i] is set, and pending[i] is cleared if edge mode.
  - With no candidate there is no side effect.
- EOI write clears INSERVICE[wd[3:0]]. Index >= NSRC, or an index not in service, has no effect.
- itr[IRQ_LINE] is registered: it is high in the cycle after a candidate exists. Other itr bits are tied 0.
- Simultaneous events:
  - A new edge and a W1C/claim clearing the same bit in the same cycle: the set wins and the bit stays pending.
  - A claim and an EOI in the same cycle: both apply.
  - EOI of index j and a claim of index j in the same cycle: set wins.
- MODE change from edge to level: the bit immediately follows s2.
- Disabling a source does not clear its pending bit.

## Timing
- Reset: ENABLE, MODE, PENDING, INSERVICE, s1, s2, p, itr are all 0. rd reflects the reset registers.
- Edge latency: src high before clock edge k gives s1 at k, s2 at k+1, pending at k+2, and itr high after k+3.
- Level latency is the same: pending follows s2 from k+1 and itr is high after k+2. Deassertion propagates with equal latency.
- Register writes take effect at the write edge. The candidate, rd and itr update from the next cycle.
- Claim latency: itr drops (or moves to the next candidate) the cycle after the claiming edge.
- Reset asserted mid-operation clears all state immediately. In-flight edges are lost.

## Test plan
- Edge source 3 enabled, src[3] pulses 1 cycle:
  - itr[2] rises 4 edges later;
  - CLAIM read returns 0x80000003;
  - PENDING[3] and itr then clear, INSERVICE = 0x08;
  - EOI 3 makes INSERVICE = 0.
- Sources 5 and 1 rise together, both edge and enabled: the first claim returns index 1, and a second claim before EOI returns 0 (5 does not outrank 1). After EOI 1, claim returns 5.
- Nesting: source 4 in service, source 2 fires. itr reasserts and claim returns 2, giving INSERVICE = 0x14.
- Level source 0 held high: a claim leaves PENDING[0]=1 and no re-fire occurs. After EOI with src still high, itr reasserts. When src drops, itr clears 3 cycles later.
- W1C on PENDING[6] in the same cycle as a new src[6] edge detection: the bit stays 1. ENABLE=0 masks itr while PENDING is retained.
- Reset asserted asynchronously with pending and in-service bits set: all registers and itr are 0 before the next clock edge.
